// File: rtl/audio_mixer_n.sv
// Time-multiplexed N-channel stereo mixer: one channel gain-MAC per cycle, then floor-shift and clamp.
// Strobe to valid_o takes NUM_CH+2 cycles; a strobe arriving mid-mix is dropped and flagged as overrun.
module audio_mixer_n #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 8
) (
  input  logic                         clk100,
  input  logic                         rst,
  input  logic                         sample_stb_i,
  input  logic [NUM_CH*SAMPLE_W-1:0]   ch_data_i,
  input  logic [NUM_CH*GAIN_W-1:0]     ch_gain_i,
  input  logic [2*NUM_CH-1:0]          ch_route_i,
  input  logic                         clr_flags_i,
  output logic [SAMPLE_W-1:0]          left_o,
  output logic [SAMPLE_W-1:0]          right_o,
  output logic                         valid_o,
  output logic                         busy_o,
  output logic                         clip_l_o,
  output logic                         clip_r_o,
  output logic                         overrun_o
);

  localparam int PW = SAMPLE_W + GAIN_W + 1;
  localparam int AW = PW + $clog2(NUM_CH);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SAT} state_t;

  state_t                       state_q;
  logic [IW-1:0]                idx_q;
  logic signed [AW-1:0]         acc_l_q, acc_r_q;
  logic [NUM_CH*SAMPLE_W-1:0]   snap_data_q;
  logic [NUM_CH*GAIN_W-1:0]     snap_gain_q;
  logic [2*NUM_CH-1:0]          snap_route_q;
  logic [SAMPLE_W-1:0]          left_q, right_q;
  logic                         valid_q, busy_q, clip_l_q, clip_r_q, overrun_q;

  logic signed [SAMPLE_W-1:0]   cur_data;
  logic [GAIN_W-1:0]            cur_gain;
  logic [1:0]                   cur_route;
  logic signed [PW-1:0]         prod;
  logic signed [AW-1:0]         prod_ext;
  logic [SAMPLE_W-1:0]          left_d, right_d;
  logic                         clip_l_d, clip_r_d;

  // Returns {clipped, sample}; the shift floors because the accumulator is signed.
  function automatic logic [SAMPLE_W:0] clamp(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] s;
    s = acc >>> (GAIN_W - 1);
    if (s > SAT_MAX)
      clamp = {1'b1, SAT_MAX[SAMPLE_W-1:0]};
    else if (s < SAT_MIN)
      clamp = {1'b1, SAT_MIN[SAMPLE_W-1:0]};
    else
      clamp = {1'b0, s[SAMPLE_W-1:0]};
  endfunction

  always_comb begin
    cur_data  = snap_data_q[idx_q*SAMPLE_W +: SAMPLE_W];
    cur_gain  = snap_gain_q[idx_q*GAIN_W +: GAIN_W];
    cur_route = snap_route_q[2*idx_q +: 2];
    prod      = PW'(cur_data) * PW'($signed({1'b0, cur_gain}));
    prod_ext  = AW'(prod);
    {clip_l_d, left_d}  = clamp(acc_l_q);
    {clip_r_d, right_d} = clamp(acc_r_q);
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      snap_data_q  <= '0;
      snap_gain_q  <= '0;
      snap_route_q <= '0;
      left_q       <= '0;
      right_q      <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      clip_l_q     <= 1'b0;
      clip_r_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clr_flags_i) begin
        clip_l_q  <= 1'b0;
        clip_r_q  <= 1'b0;
        overrun_q <= 1'b0;
      end
      // Later assignments below override the clear, so a set event wins.
      if (sample_stb_i && state_q != S_IDLE)
        overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (sample_stb_i) begin
            snap_data_q  <= ch_data_i;
            snap_gain_q  <= ch_gain_i;
            snap_route_q <= ch_route_i;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= S_ACC;
          end
        end
        S_ACC: begin
          if (cur_route[0]) acc_l_q <= acc_l_q + prod_ext;
          if (cur_route[1]) acc_r_q <= acc_r_q + prod_ext;
          idx_q <= idx_q + IW'(1);
          if (idx_q == LAST_IDX)
            state_q <= S_SAT;
        end
        S_SAT: begin
          left_q  <= left_d;
          right_q <= right_d;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          if (clip_l_d) clip_l_q <= 1'b1;
          if (clip_r_d) clip_r_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign left_o    = left_q;
  assign right_o   = right_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign clip_l_o  = clip_l_q;
  assign clip_r_o  = clip_r_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_audio_mixer_n.sv
// Bench for audio_mixer_n: directed cases plus randomized mixes against an integer reference model.
module tb_audio_mixer_n;
  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 8;
  localparam int LAT      = NUM_CH + 2;

  logic                       clk100 = 1'b0;
  logic                       rst;
  logic                       sample_stb_i;
  logic [NUM_CH*SAMPLE_W-1:0] ch_data_i;
  logic [NUM_CH*GAIN_W-1:0]   ch_gain_i;
  logic [2*NUM_CH-1:0]        ch_route_i;
  logic                       clr_flags_i;
  logic [SAMPLE_W-1:0]        left_o, right_o;
  logic                       valid_o, busy_o, clip_l_o, clip_r_o, overrun_o;

  audio_mixer_n #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W)) dut (
    .clk100(clk100), .rst(rst), .sample_stb_i(sample_stb_i),
    .ch_data_i(ch_data_i), .ch_gain_i(ch_gain_i), .ch_route_i(ch_route_i),
    .clr_flags_i(clr_flags_i), .left_o(left_o), .right_o(right_o),
    .valid_o(valid_o), .busy_o(busy_o), .clip_l_o(clip_l_o),
    .clip_r_o(clip_r_o), .overrun_o(overrun_o)
  );

  always #5 clk100 = ~clk100;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus for the next mix, kept as plain integers for the model.
  int                  d[NUM_CH];
  int                  g[NUM_CH];
  logic [2*NUM_CH-1:0] r;
  bit                  exp_clip_l, exp_clip_r;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum, floor division by unity gain, clamp to sample range.
  function automatic void model(input int side, output longint val, output bit clip);
    longint sum, q, unity, hi, lo;
    sum   = 0;
    unity = longint'(1) << (GAIN_W - 1);
    hi    = (longint'(1) << (SAMPLE_W - 1)) - 1;
    lo    = -(longint'(1) << (SAMPLE_W - 1));
    for (int i = 0; i < NUM_CH; i++)
      if (r[2*i + side]) sum += longint'(d[i]) * longint'(g[i]);
    q = sum / unity;
    if ((sum % unity) != 0 && sum < 0) q = q - 1;
    clip = 1'b0;
    if (q > hi) begin q = hi; clip = 1'b1; end
    if (q < lo) begin q = lo; clip = 1'b1; end
    val = q;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_data_i[i*SAMPLE_W +: SAMPLE_W] = d[i][SAMPLE_W-1:0];
      ch_gain_i[i*GAIN_W +: GAIN_W]     = g[i][GAIN_W-1:0];
    end
    ch_route_i = r;
  endtask

  task automatic scramble_inputs();
    ch_data_i  = {$urandom, $urandom};
    ch_gain_i  = $urandom;
    ch_route_i = 8'($urandom);
  endtask

  task automatic set_all(input int a, input int b, input int c, input int e,
                         input int gain, input logic [7:0] route);
    d[0] = a; d[1] = b; d[2] = c; d[3] = e;
    for (int i = 0; i < NUM_CH; i++) g[i] = gain;
    r = route;
  endtask

  task automatic clear_flags(input string tag);
    @(posedge clk100); #1;
    clr_flags_i = 1'b1;
    @(posedge clk100); #1;
    clr_flags_i = 1'b0;
    exp_clip_l = 1'b0;
    exp_clip_r = 1'b0;
    check_eq({tag, ".clr"}, {clip_l_o, clip_r_o, overrun_o}, 0);
  endtask

  // One strobe, bounded wait for valid_o, then latency, outputs and sticky flags.
  task automatic run_mix(input string tag);
    longint el, er;
    bit     cl, cr, got;
    int     cyc;
    model(0, el, cl);
    model(1, er, cr);
    exp_clip_l = exp_clip_l | cl;
    exp_clip_r = exp_clip_r | cr;
    @(posedge clk100); #1;
    drive_inputs();
    sample_stb_i = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < LAT + 4) begin
      @(posedge clk100); #1;
      cyc++;
      if (cyc == 1) begin
        sample_stb_i = 1'b0;
        scramble_inputs();
        check_eq({tag, ".busy"}, busy_o, 1);
      end
      if (valid_o) got = 1'b1;
    end
    check_eq({tag, ".lat"}, got ? cyc : -1, LAT);
    check_eq({tag, ".left"}, $signed(left_o), el);
    check_eq({tag, ".right"}, $signed(right_o), er);
    check_eq({tag, ".busy_end"}, busy_o, 0);
    check_eq({tag, ".clip_l"}, clip_l_o, exp_clip_l);
    check_eq({tag, ".clip_r"}, clip_r_o, exp_clip_r);
  endtask

  initial begin
    longint el, er;
    bit     cl, cr;
    int     nvalid;
    longint lv, rv;
    int     offs[2];

    rst = 1'b1;
    sample_stb_i = 1'b0;
    clr_flags_i = 1'b0;
    ch_data_i = '0;
    ch_gain_i = '0;
    ch_route_i = '0;
    exp_clip_l = 1'b0;
    exp_clip_r = 1'b0;
    #2;
    check_eq("reset.outs", {left_o, right_o, valid_o, busy_o, clip_l_o, clip_r_o, overrun_o}, 0);
    repeat (2) @(posedge clk100);
    #1 rst = 1'b0;

    set_all(1000, -500, 2000, -700, 128, 8'b1001_1001);
    run_mix("basic");

    set_all(30000, 0, 30000, 0, 128, 8'b0001_0001);
    run_mix("clip_pos");
    set_all(-30000, 0, -30000, 0, 128, 8'b0001_0001);
    run_mix("clip_neg");
    clear_flags("clip");

    set_all(1000, 0, 0, 0, 64, 8'b0000_0001);
    run_mix("gain_half");
    set_all(-1000, 0, 0, 0, 255, 8'b0000_0001);
    run_mix("gain_floor");
    set_all(30000, 30000, 30000, 30000, 0, 8'hFF);
    run_mix("gain_zero");

    set_all(1234, 0, 0, 0, 128, 8'b0000_0011);
    run_mix("both_lr");
    set_all(1234, 0, 0, 0, 128, 8'b0000_0000);
    run_mix("no_route");

    // Second strobe during ACC and during the SAT cycle must both be dropped.
    offs[0] = 2;
    offs[1] = LAT - 1;
    foreach (offs[k]) begin
      clear_flags("ovr_pre");
      set_all(1000, -500, 2000, -700, 128, 8'b1001_1001);
      model(0, el, cl);
      model(1, er, cr);
      @(posedge clk100); #1;
      drive_inputs();
      sample_stb_i = 1'b1;
      nvalid = 0;
      lv = 0;
      rv = 0;
      for (int c = 1; c <= LAT + 6; c++) begin
        @(posedge clk100); #1;
        sample_stb_i = (c == offs[k]);
        if (c == 1) scramble_inputs();
        if (valid_o) begin
          nvalid++;
          lv = $signed(left_o);
          rv = $signed(right_o);
        end
      end
      check_eq($sformatf("ovr%0d.nvalid", offs[k]), nvalid, 1);
      check_eq($sformatf("ovr%0d.left", offs[k]), lv, el);
      check_eq($sformatf("ovr%0d.right", offs[k]), rv, er);
      check_eq($sformatf("ovr%0d.flag", offs[k]), overrun_o, 1);
    end

    // Clear and overrun in the same cycle: the set wins.
    clear_flags("ovr_clr");
    @(posedge clk100); #1;
    sample_stb_i = 1'b1;
    @(posedge clk100); #1;
    clr_flags_i = 1'b1;
    @(posedge clk100); #1;
    sample_stb_i = 1'b0;
    clr_flags_i = 1'b0;
    check_eq("ovr_clr.flag", overrun_o, 1);
    repeat (LAT + 2) @(posedge clk100);
    clear_flags("ovr_post");

    // Reset during ACC abandons the mix.
    @(posedge clk100); #1;
    set_all(5000, 5000, 5000, 5000, 128, 8'hFF);
    drive_inputs();
    sample_stb_i = 1'b1;
    @(posedge clk100); #1;
    sample_stb_i = 1'b0;
    @(posedge clk100); #1;
    rst = 1'b1;
    #1;
    check_eq("rst_mid.outs", {left_o, right_o, valid_o, busy_o, clip_l_o, clip_r_o, overrun_o}, 0);
    @(posedge clk100); #1;
    rst = 1'b0;
    exp_clip_l = 1'b0;
    exp_clip_r = 1'b0;
    nvalid = 0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(posedge clk100); #1;
      if (valid_o) nvalid++;
    end
    check_eq("rst_mid.nvalid", nvalid, 0);
    set_all(1000, -500, 2000, -700, 128, 8'b1001_1001);
    run_mix("after_rst");

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 1) == 1)
          d[i] = int'($signed(16'($urandom)));
        else
          d[i] = int'($urandom_range(0, 2000)) - 1000;
        g[i] = int'($urandom_range(0, 255));
      end
      r = 8'($urandom);
      if (it % 8 == 7) clear_flags($sformatf("rnd%0d", it));
      run_mix($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
